// File: rtl/ysyx_22051013_icache_dm.sv
// rtl/ysyx_22051013_icache_dm.sv - direct-mapped blocking instruction cache, one 64-bit line per index
// Combinational lookup off the live fetch PC, registered outputs, single-beat AXI refill.
module ysyx_22051013_icache_dm #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_ena,
  input  logic [63:0] icache_inst_pc,
  input  logic        icache_ready,
  input  logic        icache_fencei,
  output logic        icache_valid,
  output logic [63:0] icache_pc,
  output logic [31:0] icache_inst,
  output logic        axi_re,
  output logic [63:0] axi_pc,
  input  logic        axi_valid,
  input  logic [63:0] axi_data
);

  localparam int TAG_W = 64 - INDEX_W - 3;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {LOOKUP, MISS} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [63:0]      data_q [LINES];

  logic [63:0] req_pc, req_pc_nxt;
  logic        fence_pend, fence_pend_nxt;

  logic        valid_nxt, re_nxt;
  logic [63:0] pc_nxt, axi_pc_nxt;
  logic [31:0] inst_nxt;
  logic        flush, fill;

  logic [INDEX_W-1:0] lk_index, fill_index;
  logic [TAG_W-1:0]   lk_tag;
  logic [63:0]        lk_line;
  logic               hit;
  logic [31:0]        hit_word, refill_word;
  logic               unused_low_bits;

  assign lk_index    = icache_inst_pc[INDEX_W+2:3];
  assign lk_tag      = icache_inst_pc[63:INDEX_W+3];
  assign lk_line     = data_q[lk_index];
  assign hit         = valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  assign hit_word    = icache_inst_pc[2] ? lk_line[63:32] : lk_line[31:0];
  assign fill_index  = req_pc[INDEX_W+2:3];
  assign refill_word = req_pc[2] ? axi_data[63:32] : axi_data[31:0];
  assign unused_low_bits = ^{icache_inst_pc[1:0], req_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= LOOKUP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOOKUP: begin
        if (!icache_fencei && !icache_ready && icache_ena && !hit) state_nxt = MISS;
      end
      MISS: begin
        if (axi_valid) state_nxt = LOOKUP;
      end
      default: state_nxt = LOOKUP;
    endcase
  end

  always_comb begin
    valid_nxt      = icache_valid;
    pc_nxt         = icache_pc;
    inst_nxt       = icache_inst;
    re_nxt         = axi_re;
    axi_pc_nxt     = axi_pc;
    req_pc_nxt     = req_pc;
    fence_pend_nxt = fence_pend;
    flush          = 1'b0;
    fill           = 1'b0;
    case (state)
      LOOKUP: begin
        if (icache_fencei) begin
          flush     = 1'b1;
          valid_nxt = 1'b0;
        end else if (icache_ready) begin
          valid_nxt = icache_valid;
        end else if (!icache_ena) begin
          valid_nxt = 1'b0;
        end else if (hit) begin
          valid_nxt = 1'b1;
          pc_nxt    = icache_inst_pc;
          inst_nxt  = hit_word;
        end else begin
          req_pc_nxt = icache_inst_pc;
          valid_nxt  = 1'b0;
          re_nxt     = 1'b1;
          axi_pc_nxt = {icache_inst_pc[63:3], 3'b000};
        end
      end
      MISS: begin
        valid_nxt = 1'b0;
        if (icache_fencei) fence_pend_nxt = 1'b1;
        if (axi_valid) begin
          re_nxt         = 1'b0;
          fence_pend_nxt = 1'b0;
          // A fence seen at any point during the refill makes the fetched line stale.
          if (fence_pend || icache_fencei) flush = 1'b1;
          else                             fill  = 1'b1;
          if (icache_ena && (icache_inst_pc == req_pc)) begin
            valid_nxt = 1'b1;
            pc_nxt    = req_pc;
            inst_nxt  = refill_word;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icache_valid <= 1'b0;
      icache_pc    <= '0;
      icache_inst  <= '0;
      axi_re       <= 1'b0;
      axi_pc       <= '0;
      req_pc       <= '0;
      fence_pend   <= 1'b0;
    end else begin
      icache_valid <= valid_nxt;
      icache_pc    <= pc_nxt;
      icache_inst  <= inst_nxt;
      axi_re       <= re_nxt;
      axi_pc       <= axi_pc_nxt;
      req_pc       <= req_pc_nxt;
      fence_pend   <= fence_pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) valid_q <= '0;
    else if (fill)    valid_q[fill_index] <= 1'b1;
  end

  // Tag and data need no reset: they are only ever read behind a valid bit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_index]  <= req_pc[63:INDEX_W+3];
      data_q[fill_index] <= axi_data;
    end
  end

endmodule
